// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared timing-mode constants and the total-length helper
// used by the raster timing generator and its axis counters.
package video_timing_pkg;

  // One axis of a timing mode, in pixel clocks (H) or lines (V).
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_mode_t;

  localparam axis_mode_t MODE_1080P60_H = '{active: 1920, fp: 88,  sync: 44, bp: 148};
  localparam axis_mode_t MODE_1080P60_V = '{active: 1080, fp: 4,   sync: 5,  bp: 36};
  localparam axis_mode_t MODE_720P60_H  = '{active: 1280, fp: 110, sync: 40, bp: 220};
  localparam axis_mode_t MODE_720P60_V  = '{active: 720,  fp: 5,   sync: 5,  bp: 20};
  localparam axis_mode_t MODE_480P60_H  = '{active: 720,  fp: 16,  sync: 62, bp: 60};
  localparam axis_mode_t MODE_480P60_V  = '{active: 480,  fp: 9,   sync: 6,  bp: 30};

  function automatic int vt_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// timing_axis_counter: one raster axis. Counts 0..TOTAL-1 on each step and
// decodes the combinational active / sync flags from the current count.
//   clock, resetN : pixel clock, async active-low reset
//   step          : advance the count this edge
//   count         : current position
//   wrap          : count is at TOTAL-1 (next step returns to 0)
//   activeFlag    : count < ACTIVE
//   syncFlag      : sync level with POL applied (POL while in the sync window)
module timing_axis_counter
  import video_timing_pkg::*;
#(
  parameter int W      = 12,
  parameter int ACTIVE = 1920,
  parameter int FP     = 88,
  parameter int SYNC   = 44,
  parameter int BP     = 148,
  parameter int POL    = 1
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         activeFlag,
  output logic         syncFlag
);

  localparam int           TOTAL  = vt_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
  // One extra bit so a sync window ending exactly at 2**W still compares right.
  localparam logic [W:0]   ACT_E  = (W+1)'(ACTIVE);
  localparam logic [W:0]   SYNC_S = (W+1)'(ACTIVE + FP);
  localparam logic [W:0]   SYNC_E = (W+1)'(ACTIVE + FP + SYNC);
  localparam logic         POL_L  = (POL != 0);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (step) cnt_d = wrap ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count      = cnt_q;
  assign wrap       = (cnt_q == LAST);
  assign activeFlag = ({1'b0, cnt_q} < ACT_E);
  assign syncFlag   = (({1'b0, cnt_q} >= SYNC_S) && ({1'b0, cnt_q} < SYNC_E)) ? POL_L : ~POL_L;

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: full raster timing generator. Two axis counters (H, V)
// feed one output register stage, so every output lags the counters by one
// clock and coordinates always line up with deOut.
//   clock, resetN        : pixel clock, async active-low reset
//   enable               : counters and registered levels advance only when 1
//   hCount, vCount       : registered coordinates
//   deOut                : inside active area
//   hSyncOut, vSyncOut   : syncs with H_POL / V_POL asserted level
//   lineStart/frameStart : 1-cycle strobes for hCount==0 / (0,0)
// Optional feature (macro VT_OVERLAY_WINDOW_EN): adds WIN_* parameters and the
// winDe / winX / winY overlay window outputs, clipped to the active area.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int busWidth = 12,
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1
`ifdef VT_OVERLAY_WINDOW_EN
  ,
  parameter int WIN_X    = 0,
  parameter int WIN_Y    = 0,
  parameter int WIN_W    = 640,
  parameter int WIN_H    = 480
`endif
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic                enable,
  output logic [busWidth-1:0] hCount,
  output logic [busWidth-1:0] vCount,
  output logic                deOut,
  output logic                hSyncOut,
  output logic                vSyncOut,
  output logic                lineStart,
  output logic                frameStart
`ifdef VT_OVERLAY_WINDOW_EN
  ,
  output logic                winDe,
  output logic [busWidth-1:0] winX,
  output logic [busWidth-1:0] winY
`endif
);

  localparam int   W      = busWidth;
  localparam logic H_IDLE = (H_POL == 0);
  localparam logic V_IDLE = (V_POL == 0);

  if (vt_total(H_ACTIVE, H_FP, H_SYNC, H_BP) > (1 << busWidth)) begin : g_bad_h
    $error("video_timing_gen: H_TOTAL exceeds 2**busWidth");
  end
  if (vt_total(V_ACTIVE, V_FP, V_SYNC, V_BP) > (1 << busWidth)) begin : g_bad_v
    $error("video_timing_gen: V_TOTAL exceeds 2**busWidth");
  end

  logic [W-1:0] h_cnt, v_cnt;
  logic         h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
  logic         unused_v_wrap;

  timing_axis_counter #(.W(W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL))
    u_h (.clock(clock), .resetN(resetN), .step(enable), .count(h_cnt),
         .wrap(h_wrap), .activeFlag(h_act), .syncFlag(h_sync));

  timing_axis_counter #(.W(W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL))
    u_v (.clock(clock), .resetN(resetN), .step(h_wrap && enable), .count(v_cnt),
         .wrap(v_wrap), .activeFlag(v_act), .syncFlag(v_sync));

  // The frame end is implied by the H/V counts; V wrap is not needed here.
  assign unused_v_wrap = v_wrap;

  logic [W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic         de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic         line_start_q, line_start_d, frame_start_q, frame_start_d;

  // Levels hold while disabled; strobes only fire on an advancing edge so a
  // paused raster never repeats a line/frame start.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    de_d          = de_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (enable) begin
      hcount_d      = h_cnt;
      vcount_d      = v_cnt;
      de_d          = h_act && v_act;
      hsync_d       = h_sync;
      vsync_d       = v_sync;
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      de_q          <= 1'b0;
      hsync_q       <= H_IDLE;
      vsync_q       <= V_IDLE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hCount     = hcount_q;
  assign vCount     = vcount_q;
  assign deOut      = de_q;
  assign hSyncOut   = hsync_q;
  assign vSyncOut   = vsync_q;
  assign lineStart  = line_start_q;
  assign frameStart = frame_start_q;

`ifdef VT_OVERLAY_WINDOW_EN
  // Window edges clipped to the active area; widened by one bit so an edge
  // at 2**W compares correctly.
  localparam int         X_END_I = (WIN_X + WIN_W < H_ACTIVE) ? WIN_X + WIN_W : H_ACTIVE;
  localparam int         Y_END_I = (WIN_Y + WIN_H < V_ACTIVE) ? WIN_Y + WIN_H : V_ACTIVE;
  localparam logic [W:0] X_LO    = (W+1)'(WIN_X);
  localparam logic [W:0] Y_LO    = (W+1)'(WIN_Y);
  localparam logic [W:0] X_HI    = (W+1)'(X_END_I);
  localparam logic [W:0] Y_HI    = (W+1)'(Y_END_I);

  logic         win_in;
  logic         win_de_q, win_de_d;
  logic [W-1:0] win_x_q, win_x_d, win_y_q, win_y_d;

  assign win_in = ({1'b0, h_cnt} >= X_LO) && ({1'b0, h_cnt} < X_HI) &&
                  ({1'b0, v_cnt} >= Y_LO) && ({1'b0, v_cnt} < Y_HI);

  always_comb begin
    win_de_d = win_de_q;
    win_x_d  = win_x_q;
    win_y_d  = win_y_q;
    if (enable) begin
      win_de_d = win_in;
      win_x_d  = win_in ? h_cnt - X_LO[W-1:0] : '0;
      win_y_d  = win_in ? v_cnt - Y_LO[W-1:0] : '0;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      win_de_q <= 1'b0;
      win_x_q  <= '0;
      win_y_q  <= '0;
    end else begin
      win_de_q <= win_de_d;
      win_x_q  <= win_x_d;
      win_y_q  <= win_y_d;
    end
  end

  assign winDe = win_de_q;
  assign winX  = win_x_q;
  assign winY  = win_y_q;
`endif

endmodule
